// File: rtl/wishbone_lsu.sv
// MEM-stage load/store unit: turns a MEM-stage request into a classic Wishbone B4 cycle,
// stalls the pipeline while the cycle is outstanding, and returns extended load data.
// Optional build macro WB_TIMEOUT_EN: a REQ cycle that is never terminated by the slave
// ends as an error after TIMEOUT_CYCLES cycles in REQ.
module wishbone_lsu #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  MEM_REQ,
    input  logic                  MEM_WE,
    input  logic [2:0]            MEM_FUNCT3,
    input  logic [31:0]           MEM_ADDR,
    input  logic [31:0]           MEM_WDATA,
    input  logic                  MEM_KILL,
    output logic                  WB_CYC_O,
    output logic                  WB_STB_O,
    output logic                  WB_WE_O,
    output logic [ADDR_WIDTH-1:0] WB_ADR_O,
    output logic [31:0]           WB_DAT_O,
    output logic [3:0]            WB_SEL_O,
    input  logic [31:0]           WB_DAT_I,
    input  logic                  WB_ACK_I,
    input  logic                  WB_ERR_I,
    output logic                  WISHBONE_BUSY,
    output logic [31:0]           LOAD_RDATA,
    output logic                  MEM_ACCESS_FAULT,
    output logic                  MEM_MISALIGNED
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    cyc_q, cyc_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [31:0]             dat_q, dat_d;
    logic [3:0]              sel_q, sel_d;
    logic [1:0]              off_q, off_d;
    logic [2:0]              f3_q, f3_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    fault_q, fault_d;
    logic                    busy;

    logic                    misaligned_c;
    logic                    issue_c;
    logic                    timeout_c;
    logic                    term_err_c;
    logic                    term_ack_c;
    logic                    done_c;
    logic [3:0]              sel_c;
    logic [31:0]             wdat_c;
    logic [31:0]             shifted_c;
    logic [31:0]             load_ext_c;

    // Halfword needs a[0]=0, word needs a[1:0]=0; bytes are always aligned
    always_comb begin
        misaligned_c = 1'b0;
        if (MEM_REQ) begin
            case (MEM_FUNCT3[1:0])
                2'b00:   misaligned_c = 1'b0;
                2'b01:   misaligned_c = MEM_ADDR[0];
                default: misaligned_c = (MEM_ADDR[1:0] != 2'b00);
            endcase
        end
    end

    assign MEM_MISALIGNED = misaligned_c;
    assign issue_c        = (state_q == S_IDLE) && MEM_REQ && !MEM_KILL && !misaligned_c;

`ifdef WB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q;

    // Counts REQ cycles; cnt_q == k-1 in the k-th REQ cycle
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_q <= '0;
        end else if (issue_c) begin
            cnt_q <= '0;
        end else if (state_q == S_REQ) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign timeout_c = (state_q == S_REQ) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_c = 1'b0;
`endif

    // ERR wins over a simultaneous ACK; a timeout only fires when the slave is silent
    assign term_err_c = (state_q == S_REQ) && (WB_ERR_I || (timeout_c && !WB_ACK_I));
    assign term_ack_c = (state_q == S_REQ) && WB_ACK_I && !WB_ERR_I;
    assign done_c     = term_err_c || term_ack_c;

    // Store lane formatting from the request being issued
    always_comb begin
        sel_c  = 4'b1111;
        wdat_c = MEM_WDATA;
        case (MEM_FUNCT3[1:0])
            2'b00: begin
                sel_c  = 4'(4'b0001 << MEM_ADDR[1:0]);
                wdat_c = {4{MEM_WDATA[7:0]}};
            end
            2'b01: begin
                sel_c  = 4'(4'b0011 << MEM_ADDR[1:0]);
                wdat_c = {2{MEM_WDATA[15:0]}};
            end
            default: begin
                sel_c  = 4'b1111;
                wdat_c = MEM_WDATA;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension using the latched offset and funct3
    always_comb begin
        shifted_c  = WB_DAT_I >> {off_q, 3'b000};
        load_ext_c = shifted_c;
        case (f3_q[1:0])
            2'b00:   load_ext_c = f3_q[2] ? {24'd0, shifted_c[7:0]}
                                          : {{24{shifted_c[7]}}, shifted_c[7:0]};
            2'b01:   load_ext_c = f3_q[2] ? {16'd0, shifted_c[15:0]}
                                          : {{16{shifted_c[15]}}, shifted_c[15:0]};
            default: load_ext_c = shifted_c;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue_c) state_d = S_REQ;
            S_REQ:   if (done_c)  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: stall request and next values of the registered bus/result outputs
    always_comb begin
        busy    = 1'b0;
        cyc_d   = cyc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy = issue_c;
                if (issue_c) begin
                    cyc_d = 1'b1;
                    we_d  = MEM_WE;
                    adr_d = {MEM_ADDR[ADDR_WIDTH-1:2], 2'b00};
                    dat_d = wdat_c;
                    sel_d = sel_c;
                    off_d = MEM_ADDR[1:0];
                    f3_d  = MEM_FUNCT3;
                end
            end
            S_REQ: begin
                busy = !done_c;
                if (done_c) begin
                    cyc_d = 1'b0;
                end
                if (term_err_c) begin
                    rdata_d = 32'd0;
                    fault_d = 1'b1;
                end else if (term_ack_c && !we_q) begin
                    rdata_d = load_ext_c;
                end
            end
            default: begin
                cyc_d = 1'b0;
            end
        endcase
    end

    // Registered Wishbone master outputs and load result
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= 32'd0;
            sel_q   <= 4'd0;
            off_q   <= 2'd0;
            f3_q    <= 3'd0;
            rdata_q <= 32'd0;
            fault_q <= 1'b0;
        end else begin
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end

    assign WB_CYC_O         = cyc_q;
    assign WB_STB_O         = cyc_q;
    assign WB_WE_O          = we_q;
    assign WB_ADR_O         = adr_q;
    assign WB_DAT_O         = dat_q;
    assign WB_SEL_O         = sel_q;
    assign LOAD_RDATA       = rdata_q;
    assign MEM_ACCESS_FAULT = fault_q;
    assign WISHBONE_BUSY    = busy;

endmodule
